// File: rtl/r_addr_track.sv
// Read-address tracker: records each accepted AR (id plus decoded slave select) and routes
// returning R beats back by RID, retiring the entry on the RLAST handshake.
module r_addr_track #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  s_arvalid,
  input  logic                  m_arready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  rd_state_refre,
  input  logic                  m_rvalid,
  input  logic                  s_rready,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic                  m_rlast,
  output logic                  ar_stall,
  output logic [SEL_WIDTH-1:0]  m_rvalid_sel,
  output logic                  rd_hit,
  output logic                  m_rvalid_sel_en,
  output logic                  s_araddr_en,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic                  rd_reg_flag
);

  logic [DEPTH-1:0]     r_valid;
  logic [ID_WIDTH-1:0]  r_id  [DEPTH];
  logic [SEL_WIDTH-1:0] r_sel [DEPTH];
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_flag;
  logic                 r_arvalid_d;
  logic                 r_rvalid_d;

  logic [DEPTH-1:0]     w_dup_vec;
  logic [DEPTH-1:0]     w_rid_match;
  logic [DEPTH-1:0]     w_alloc_oh;
  logic [SEL_WIDTH-1:0] w_ar_sel;
  logic                 w_alloc;
  logic                 w_free;
  logic                 w_refresh;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  assign w_ar_sel = s_araddr[ADDR_WIDTH-1 -: SEL_WIDTH];

  always_comb begin
    w_dup_vec    = '0;
    w_rid_match  = '0;
    w_alloc_oh   = '0;
    m_rvalid_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_dup_vec[i]   = r_valid[i] && (r_id[i] == s_arid);
      w_rid_match[i] = r_valid[i] && (r_id[i] == m_rid);
    end
    // Descending scan so the lowest-index invalid slot wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_alloc_oh    = '0;
        w_alloc_oh[i] = 1'b1;
      end
    end
    // IDs are unique in the table, so at most one entry contributes here.
    for (int i = 0; i < DEPTH; i++) begin
      if (m_rvalid && w_rid_match[i]) begin
        m_rvalid_sel = m_rvalid_sel | r_sel[i];
      end
    end
  end

  assign ar_stall  = (&r_valid) | (s_arvalid & (|w_dup_vec));
  assign rd_hit    = m_rvalid & (|w_rid_match);
  assign w_alloc   = s_arvalid & m_arready & ~ar_stall;
  assign w_free    = m_rvalid & s_rready & m_rlast & rd_hit;
  assign w_refresh = rd_state_refre & ~w_alloc & ~w_free;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_refresh) begin
      w_cnt_nxt = '0;
    end else if (w_alloc && !w_free) begin
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end else if (w_free && !w_alloc) begin
      w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_valid     <= '0;
      r_cnt       <= '0;
      r_flag      <= 1'b0;
      r_arvalid_d <= 1'b0;
      r_rvalid_d  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]  <= '0;
        r_sel[i] <= '0;
      end
    end else begin
      r_arvalid_d <= s_arvalid;
      r_rvalid_d  <= m_rvalid;
      r_cnt       <= w_cnt_nxt;
      r_flag      <= (w_cnt_nxt >= CNT_WIDTH'(2));
      if (w_refresh) begin
        r_valid <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_id[i]  <= '0;
          r_sel[i] <= '0;
        end
      end else begin
        r_valid <= (r_valid & ~({DEPTH{w_free}} & w_rid_match)) |
                   ({DEPTH{w_alloc}} & w_alloc_oh);
        for (int i = 0; i < DEPTH; i++) begin
          if (w_alloc && w_alloc_oh[i]) begin
            r_id[i]  <= s_arid;
            r_sel[i] <= w_ar_sel;
          end
        end
      end
    end
  end

  assign rd_cnt          = r_cnt;
  assign rd_reg_flag     = r_flag;
  assign s_araddr_en     = r_arvalid_d;
  assign m_rvalid_sel_en = r_rvalid_d;

endmodule

// File: tb/tb_r_addr_track.sv
// Directed bench for r_addr_track: allocation, stall, lookup, retire, refresh and reset.
module tb_r_addr_track;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        s_arvalid = 1'b0;
  logic        m_arready = 1'b0;
  logic [3:0]  s_arid = '0;
  logic [31:0] s_araddr = '0;
  logic        rd_state_refre = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        s_rready = 1'b0;
  logic [3:0]  m_rid = '0;
  logic        m_rlast = 1'b0;
  logic        ar_stall;
  logic [1:0]  m_rvalid_sel;
  logic        rd_hit;
  logic        m_rvalid_sel_en;
  logic        s_araddr_en;
  logic [2:0]  rd_cnt;
  logic        rd_reg_flag;

  int n_pass = 0;
  int n_checks = 0;

  always #5 sys_clk = ~sys_clk;

  r_addr_track dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .s_arvalid      (s_arvalid),
    .m_arready      (m_arready),
    .s_arid         (s_arid),
    .s_araddr       (s_araddr),
    .rd_state_refre (rd_state_refre),
    .m_rvalid       (m_rvalid),
    .s_rready       (s_rready),
    .m_rid          (m_rid),
    .m_rlast        (m_rlast),
    .ar_stall       (ar_stall),
    .m_rvalid_sel   (m_rvalid_sel),
    .rd_hit         (rd_hit),
    .m_rvalid_sel_en(m_rvalid_sel_en),
    .s_araddr_en    (s_araddr_en),
    .rd_cnt         (rd_cnt),
    .rd_reg_flag    (rd_reg_flag)
  );

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_arvalid = 1'b0; m_arready = 1'b0; s_arid = '0; s_araddr = '0;
    rd_state_refre = 1'b0; m_rvalid = 1'b0; s_rready = 1'b0; m_rid = '0; m_rlast = 1'b0;
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr);
    s_arvalid = 1'b1; m_arready = 1'b1; s_arid = id; s_araddr = addr;
    step();
    s_arvalid = 1'b0; m_arready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (rd_cnt !== 3'd0) $display("FAIL reset_cnt got=%0d exp=0", rd_cnt); else n_pass++;
    n_checks++;
    if (rd_reg_flag !== 1'b0) $display("FAIL reset_flag got=%b exp=0", rd_reg_flag);
    else n_pass++;
    n_checks++;
    if ({s_araddr_en, m_rvalid_sel_en} !== 2'b00)
      $display("FAIL reset_en got=%b exp=00", {s_araddr_en, m_rvalid_sel_en});
    else n_pass++;
    n_checks++;
    if (ar_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", ar_stall); else n_pass++;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    ar_hs(4'd3, 32'h8000_0000);
    n_checks++;
    if (rd_cnt !== 3'd1) $display("FAIL single_cnt got=%0d exp=1", rd_cnt); else n_pass++;
    n_checks++;
    if (rd_reg_flag !== 1'b0) $display("FAIL single_flag got=%b exp=0", rd_reg_flag);
    else n_pass++;
    n_checks++;
    if (s_araddr_en !== 1'b1) $display("FAIL single_araddr_en got=%b exp=1", s_araddr_en);
    else n_pass++;
    m_rvalid = 1'b1; s_rready = 1'b1; m_rid = 4'd3; m_rlast = 1'b0;
    #1;
    n_checks++;
    if ({rd_hit, m_rvalid_sel} !== 3'b1_10)
      $display("FAIL single_lookup got=%b exp=110", {rd_hit, m_rvalid_sel});
    else n_pass++;
    step();
    n_checks++;
    if (m_rvalid_sel_en !== 1'b1) $display("FAIL single_rvalid_en got=%b exp=1", m_rvalid_sel_en);
    else n_pass++;
    n_checks++;
    if (rd_cnt !== 3'd1) $display("FAIL single_nonlast_cnt got=%0d exp=1", rd_cnt); else n_pass++;
    m_rlast = 1'b1;
    step();
    n_checks++;
    if (rd_cnt !== 3'd0) $display("FAIL single_retire_cnt got=%0d exp=0", rd_cnt); else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) ar_hs(4'(i), 32'(i) << 30);
    n_checks++;
    if ({rd_cnt, rd_reg_flag} !== {3'd4, 1'b1})
      $display("FAIL full_cnt_flag got=%0d/%b exp=4/1", rd_cnt, rd_reg_flag);
    else n_pass++;
    n_checks++;
    if (ar_stall !== 1'b1) $display("FAIL full_stall got=%b exp=1", ar_stall); else n_pass++;
    ar_hs(4'd9, 32'h4000_0000);
    n_checks++;
    if (rd_cnt !== 3'd4) $display("FAIL full_fifth_cnt got=%0d exp=4", rd_cnt); else n_pass++;
    m_rvalid = 1'b1; m_rid = 4'd9;
    #1;
    n_checks++;
    if (rd_hit !== 1'b0) $display("FAIL full_fifth_hit got=%b exp=0", rd_hit); else n_pass++;
    m_rid = 4'd2;
    #1;
    n_checks++;
    if ({rd_hit, m_rvalid_sel} !== 3'b1_10)
      $display("FAIL full_lookup2 got=%b exp=110", {rd_hit, m_rvalid_sel});
    else n_pass++;
    m_rvalid = 1'b0;
  endtask

  // Table holds ids 0..3 on entry.
  task automatic test_simul();
    s_arvalid = 1'b1; m_arready = 1'b1; s_arid = 4'd7; s_araddr = 32'hC000_0000;
    m_rvalid = 1'b1; s_rready = 1'b1; m_rid = 4'd2; m_rlast = 1'b1;
    #1;
    n_checks++;
    if (ar_stall !== 1'b1) $display("FAIL simul_full_stall got=%b exp=1", ar_stall); else n_pass++;
    step();
    n_checks++;
    if (rd_cnt !== 3'd3) $display("FAIL simul_free_cnt got=%0d exp=3", rd_cnt); else n_pass++;
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    n_checks++;
    if (ar_stall !== 1'b0) $display("FAIL simul_unstall got=%b exp=0", ar_stall); else n_pass++;
    step();
    s_arvalid = 1'b0;
    m_rvalid = 1'b1; m_rid = 4'd7;
    #1;
    n_checks++;
    if ({rd_cnt, rd_hit, m_rvalid_sel} !== {3'd4, 1'b1, 2'b11})
      $display("FAIL simul_id7 got=%0d/%b/%b exp=4/1/11", rd_cnt, rd_hit, m_rvalid_sel);
    else n_pass++;
    m_rid = 4'd1; m_rlast = 1'b1;
    step();
    // One slot free: alloc id 10 and retire id 3 in the same cycle.
    s_arvalid = 1'b1; m_arready = 1'b1; s_arid = 4'd10; s_araddr = 32'h4000_0000;
    m_rid = 4'd3; m_rlast = 1'b1;
    step();
    s_arvalid = 1'b0; m_rlast = 1'b0;
    n_checks++;
    if (rd_cnt !== 3'd3) $display("FAIL simul_both_cnt got=%0d exp=3", rd_cnt); else n_pass++;
    m_rid = 4'd10;
    #1;
    n_checks++;
    if ({rd_hit, m_rvalid_sel} !== 3'b1_01)
      $display("FAIL simul_id10 got=%b exp=101", {rd_hit, m_rvalid_sel});
    else n_pass++;
    m_rid = 4'd3;
    #1;
    n_checks++;
    if (rd_hit !== 1'b0) $display("FAIL simul_id3_gone got=%b exp=0", rd_hit); else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_refresh();
    rd_state_refre = 1'b1;
    step();
    rd_state_refre = 1'b0;
    n_checks++;
    if ({rd_cnt, rd_reg_flag} !== {3'd0, 1'b0})
      $display("FAIL refresh_clear got=%0d/%b exp=0/0", rd_cnt, rd_reg_flag);
    else n_pass++;
    m_rvalid = 1'b1; m_rid = 4'd0;
    #1;
    n_checks++;
    if (rd_hit !== 1'b0) $display("FAIL refresh_id0_gone got=%b exp=0", rd_hit); else n_pass++;
    m_rvalid = 1'b0;
    rd_state_refre = 1'b1;
    ar_hs(4'd4, 32'h0000_0000);
    rd_state_refre = 1'b0;
    n_checks++;
    if (rd_cnt !== 3'd1) $display("FAIL refresh_ignored got=%0d exp=1", rd_cnt); else n_pass++;
    m_rvalid = 1'b1; m_rid = 4'd12;
    #1;
    n_checks++;
    if ({rd_hit, m_rvalid_sel} !== 3'b0_00)
      $display("FAIL refresh_unknown got=%b exp=000", {rd_hit, m_rvalid_sel});
    else n_pass++;
    m_rvalid = 1'b0;
  endtask

  // id 4 is outstanding on entry.
  task automatic test_dup();
    s_arid = 4'd4;
    #1;
    n_checks++;
    if (ar_stall !== 1'b0) $display("FAIL dup_novalid got=%b exp=0", ar_stall); else n_pass++;
    s_arvalid = 1'b1;
    #1;
    n_checks++;
    if (ar_stall !== 1'b1) $display("FAIL dup_same got=%b exp=1", ar_stall); else n_pass++;
    s_arid = 4'd6;
    #1;
    n_checks++;
    if (ar_stall !== 1'b0) $display("FAIL dup_other got=%b exp=0", ar_stall); else n_pass++;
    idle_inputs();
    rd_state_refre = 1'b1;
    step();
    rd_state_refre = 1'b0;
  endtask

  task automatic test_burst();
    ar_hs(4'd1, 32'h4000_0000);
    m_rvalid = 1'b1; s_rready = 1'b1; m_rid = 4'd1;
    for (int b = 0; b < 4; b++) begin
      m_rlast = (b == 3);
      step();
      n_checks++;
      if (rd_cnt !== ((b == 3) ? 3'd0 : 3'd1))
        $display("FAIL burst_beat%0d_cnt got=%0d exp=%0d", b, rd_cnt, (b == 3) ? 0 : 1);
      else n_pass++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_async_reset();
    ar_hs(4'd2, 32'h0000_0000);
    ar_hs(4'd5, 32'h0000_0000);
    #2;
    sys_rst = 1'b1;
    #1;
    n_checks++;
    if ({rd_cnt, rd_reg_flag} !== {3'd0, 1'b0})
      $display("FAIL async_rst got=%0d/%b exp=0/0", rd_cnt, rd_reg_flag);
    else n_pass++;
    m_rvalid = 1'b1; m_rid = 4'd5;
    #1;
    n_checks++;
    if (rd_hit !== 1'b0) $display("FAIL async_rst_hit got=%b exp=0", rd_hit); else n_pass++;
    idle_inputs();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_simul();
    test_refresh();
    test_dup();
    test_burst();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
